// File: rtl/wired_rename_nway_pkg.sv
// Shared types and helpers for the N-lane rename stage.
package wired_rename_nway_pkg;

   localparam int unsigned ARCH_REGS_DEF = 32;
   localparam int unsigned ROB_DEPTH_DEF = 64;
   localparam int unsigned AW_DEF        = $clog2(ARCH_REGS_DEF);
   localparam int unsigned RW_DEF        = $clog2(ROB_DEPTH_DEF);

   typedef logic [AW_DEF-1:0] arch_rid_t;
   typedef logic [RW_DEF-1:0] rob_rid_t;

   // One map table slot: producer still in flight, and which ROB entry it is.
   typedef struct packed {
      logic     busy;
      rob_rid_t rob_id;
   } rename_map_entry_t;

   // Population count of up to 8 lanes.
   function automatic logic [3:0] popcount(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int k = 0; k < 8; k++) c = c + {3'b000, v[k]};
      return c;
   endfunction

endpackage

// File: rtl/wired_rename_map.sv
// Arch -> ROB map table: forwarded read ports, commit clears, priority rename writes.
module wired_rename_map
   import wired_rename_nway_pkg::*;
#(
   parameter int unsigned WIDTH     = 2,
   parameter int unsigned RPORTS    = 2,
   parameter int unsigned ARCH_REGS = ARCH_REGS_DEF,
   parameter int unsigned AW        = AW_DEF,
   parameter int unsigned RW        = RW_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [WIDTH*RPORTS*AW-1:0] rd_arch,
   output logic [WIDTH*RPORTS-1:0]    rd_busy,
   output logic [WIDTH*RPORTS*RW-1:0] rd_id,
   input  logic [WIDTH-1:0]           fwd_en,
   input  logic [WIDTH*RW-1:0]        fwd_id,
   input  logic [WIDTH-1:0]           wr_en,
   input  logic [WIDTH*AW-1:0]        wr_arch,
   input  logic [WIDTH*RW-1:0]        wr_id,
   input  logic [WIDTH-1:0]           clr_en,
   input  logic [WIDTH*AW-1:0]        clr_arch,
   input  logic [WIDTH*RW-1:0]        clr_id
);

   rename_map_entry_t map_q [ARCH_REGS];
   rename_map_entry_t map_d [ARCH_REGS];
   rename_map_entry_t rd_ent;
   logic              fwd_hit;

   // Read ports; a producer committing this cycle is reported as not busy.
   always_comb begin
      rd_busy = '0;
      rd_id   = '0;
      rd_ent  = '0;
      fwd_hit = 1'b0;
      for (int p = 0; p < WIDTH*RPORTS; p++) begin
         rd_ent  = map_q[rd_arch[p*AW +: AW]];
         fwd_hit = 1'b0;
         for (int k = 0; k < WIDTH; k++) begin
            if (fwd_en[k] && (fwd_id[k*RW +: RW] == rd_ent.rob_id)) fwd_hit = 1'b1;
         end
         rd_busy[p]        = rd_ent.busy & ~fwd_hit;
         rd_id[p*RW +: RW] = rd_ent.rob_id;
      end
   end

   // Next state: clears first so a same-cycle rename write overrides them; flush wins.
   always_comb begin
      map_d = map_q;
      for (int k = 0; k < WIDTH; k++) begin
         if (clr_en[k] && (clr_arch[k*AW +: AW] != '0) &&
             (map_q[clr_arch[k*AW +: AW]].rob_id == clr_id[k*RW +: RW])) begin
            map_d[clr_arch[k*AW +: AW]].busy = 1'b0;
         end
      end
      // Ascending order: highest lane writing an arch wins.
      for (int k = 0; k < WIDTH; k++) begin
         if (wr_en[k] && (wr_arch[k*AW +: AW] != '0)) begin
            map_d[wr_arch[k*AW +: AW]].busy   = 1'b1;
            map_d[wr_arch[k*AW +: AW]].rob_id = wr_id[k*RW +: RW];
         end
      end
      if (flush) begin
         for (int a = 0; a < ARCH_REGS; a++) map_d[a] = '0;
      end
   end

   // Map table storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int a = 0; a < ARCH_REGS; a++) map_q[a] <= '0;
      end else begin
         for (int a = 0; a < ARCH_REGS; a++) map_q[a] <= map_d[a];
      end
   end

endmodule

// File: rtl/wired_rename_nway.sv
// N-lane rename stage: skid input, in-order ROB id allocation, map lookup with bypass.
module wired_rename_nway
   import wired_rename_nway_pkg::*;
#(
   parameter int unsigned WIDTH     = 2,
   parameter int unsigned RPORTS    = 2,
   parameter int unsigned ARCH_REGS = ARCH_REGS_DEF,
   parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEF,
   parameter int unsigned AW        = $clog2(ARCH_REGS),
   parameter int unsigned RW        = $clog2(ROB_DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [WIDTH-1:0]           in_mask_i,
   input  logic [WIDTH*RPORTS*AW-1:0] in_rarid_i,
   input  logic [WIDTH*AW-1:0]        in_warid_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [WIDTH-1:0]           out_mask_o,
   output logic [WIDTH*RPORTS*RW-1:0] out_rrrid_o,
   output logic [WIDTH*RPORTS-1:0]    out_rbusy_o,
   output logic [WIDTH*RW-1:0]        out_wrrid_o,
   output logic [WIDTH-1:0]           out_tier_o,
   output logic [WIDTH*AW-1:0]        out_warid_o,
   input  logic [WIDTH-1:0]           c_retire_i,
   input  logic [WIDTH*AW-1:0]        c_warid_i,
   input  logic [WIDTH*RW-1:0]        c_wrrid_i,
   input  logic                       c_flush_i,
   output logic                       empty_o
);

   logic                       skid_valid_q;
   logic [WIDTH-1:0]           skid_mask_q;
   logic [WIDTH*RPORTS*AW-1:0] skid_rarid_q;
   logic [WIDTH*AW-1:0]        skid_warid_q;

   logic                       s_valid;
   logic [WIDTH-1:0]           s_mask;
   logic [WIDTH*RPORTS*AW-1:0] s_rarid;
   logic [WIDTH*AW-1:0]        s_warid;

   logic [RW:0]   head_q, tail_q, occ, lane_sum;
   logic [RW+1:0] free;
   logic [3:0]    cnt, ret_cnt;
   logic          fire;

   logic [WIDTH*RW-1:0]        a_id;
   logic [WIDTH-1:0]           a_tier;
   logic [WIDTH-1:0]           wr_en;
   logic [WIDTH*RPORTS-1:0]    map_busy, src_busy;
   logic [WIDTH*RPORTS*RW-1:0] map_id, src_id;

   logic                       out_valid_q;
   logic [WIDTH-1:0]           out_mask_q, out_tier_q;
   logic [WIDTH*RPORTS*RW-1:0] out_rrrid_q;
   logic [WIDTH*RPORTS-1:0]    out_rbusy_q;
   logic [WIDTH*RW-1:0]        out_wrrid_q;
   logic [WIDTH*AW-1:0]        out_warid_q;

   assign in_ready_o = ~skid_valid_q;
   assign s_valid    = skid_valid_q | in_valid_i;
   assign s_mask     = skid_valid_q ? skid_mask_q  : in_mask_i;
   assign s_rarid    = skid_valid_q ? skid_rarid_q : in_rarid_i;
   assign s_warid    = skid_valid_q ? skid_warid_q : in_warid_i;

   // Pointers carry a wrap bit so full and empty are distinguishable.
   assign occ     = tail_q - head_q;
   assign free    = (RW+2)'(ROB_DEPTH) - {1'b0, occ};
   assign ret_cnt = popcount(8'(c_retire_i));
   assign empty_o = (head_q == tail_q);
   assign fire    = s_valid & (~out_valid_q | out_ready_i) & (free >= (RW+2)'(cnt)) & ~c_flush_i;

   // Compacted allocation: each masked lane takes tail plus the masked lanes below it.
   always_comb begin
      cnt      = '0;
      lane_sum = '0;
      a_id     = '0;
      a_tier   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         lane_sum = tail_q + (RW+1)'(cnt);
         if (s_mask[i]) begin
            a_id[i*RW +: RW] = lane_sum[RW-1:0];
            a_tier[i]        = lane_sum[RW];
         end
         cnt = cnt + {3'b000, s_mask[i]};
      end
   end

   // Source lookup: map value, overridden by the nearest earlier lane writing the same arch.
   always_comb begin
      src_busy = '0;
      src_id   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         for (int r = 0; r < RPORTS; r++) begin
            src_busy[i*RPORTS+r]            = map_busy[i*RPORTS+r];
            src_id[(i*RPORTS+r)*RW +: RW]   = map_id[(i*RPORTS+r)*RW +: RW];
            for (int j = 0; j < i; j++) begin
               if (s_mask[j] && (s_warid[j*AW +: AW] == s_rarid[(i*RPORTS+r)*AW +: AW])) begin
                  src_busy[i*RPORTS+r]          = 1'b1;
                  src_id[(i*RPORTS+r)*RW +: RW] = a_id[j*RW +: RW];
               end
            end
            if (!s_mask[i] || (s_rarid[(i*RPORTS+r)*AW +: AW] == '0)) begin
               src_busy[i*RPORTS+r]          = 1'b0;
               src_id[(i*RPORTS+r)*RW +: RW] = '0;
            end
         end
      end
   end

   // Rename writes: masked lanes with a real destination.
   always_comb begin
      wr_en = '0;
      for (int i = 0; i < WIDTH; i++) begin
         wr_en[i] = fire & s_mask[i] & (s_warid[i*AW +: AW] != '0);
      end
   end

   wired_rename_map #(
      .WIDTH     (WIDTH),
      .RPORTS    (RPORTS),
      .ARCH_REGS (ARCH_REGS),
      .AW        (AW),
      .RW        (RW)
   ) u_map (
      .clk      (clk),
      .rst      (rst),
      .flush    (c_flush_i),
      .rd_arch  (s_rarid),
      .rd_busy  (map_busy),
      .rd_id    (map_id),
      .fwd_en   (c_retire_i),
      .fwd_id   (c_wrrid_i),
      .wr_en    (wr_en),
      .wr_arch  (s_warid),
      .wr_id    (a_id),
      .clr_en   (c_retire_i & {WIDTH{~c_flush_i}}),
      .clr_arch (c_warid_i),
      .clr_id   (c_wrrid_i)
   );

   // Head/tail pointers; flush resets both and drops any same-cycle commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
      end else if (c_flush_i) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_q + (RW+1)'(ret_cnt);
         if (fire) tail_q <= tail_q + (RW+1)'(cnt);
      end
   end

   // Skid register: captures an accepted bundle that could not fire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_valid_q <= 1'b0;
         skid_mask_q  <= '0;
         skid_rarid_q <= '0;
         skid_warid_q <= '0;
      end else if (c_flush_i) begin
         skid_valid_q <= 1'b0;
      end else if (skid_valid_q) begin
         if (fire) skid_valid_q <= 1'b0;
      end else if (in_valid_i && !fire) begin
         skid_valid_q <= 1'b1;
         skid_mask_q  <= in_mask_i;
         skid_rarid_q <= in_rarid_i;
         skid_warid_q <= in_warid_i;
      end
   end

   // Output register: loads on fire, holds while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_mask_q  <= '0;
         out_rrrid_q <= '0;
         out_rbusy_q <= '0;
         out_wrrid_q <= '0;
         out_tier_q  <= '0;
         out_warid_q <= '0;
      end else if (c_flush_i) begin
         out_valid_q <= 1'b0;
      end else if (fire) begin
         out_valid_q <= 1'b1;
         out_mask_q  <= s_mask;
         out_rrrid_q <= src_id;
         out_rbusy_q <= src_busy;
         out_wrrid_q <= a_id;
         out_tier_q  <= a_tier;
         out_warid_q <= s_warid;
      end else if (out_ready_i) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_mask_o  = out_mask_q;
   assign out_rrrid_o = out_rrrid_q;
   assign out_rbusy_o = out_rbusy_q;
   assign out_wrrid_o = out_wrrid_q;
   assign out_tier_o  = out_tier_q;
   assign out_warid_o = out_warid_q;

endmodule

// File: tb/tb_wired_rename_nway.sv
// Directed bench for wired_rename_nway with default parameters (2 lanes, 2 ports, 32 regs, 64 ROB).
module tb_wired_rename_nway;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [1:0]  in_mask_i;
   logic [19:0] in_rarid_i;
   logic [9:0]  in_warid_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [1:0]  out_mask_o;
   logic [23:0] out_rrrid_o;
   logic [3:0]  out_rbusy_o;
   logic [11:0] out_wrrid_o;
   logic [1:0]  out_tier_o;
   logic [9:0]  out_warid_o;
   logic [1:0]  c_retire_i;
   logic [9:0]  c_warid_i;
   logic [11:0] c_wrrid_i;
   logic        c_flush_i;
   logic        empty_o;

   int checks = 0;
   int errors = 0;

   wired_rename_nway dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_mask_i   (in_mask_i),
      .in_rarid_i  (in_rarid_i),
      .in_warid_i  (in_warid_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_mask_o  (out_mask_o),
      .out_rrrid_o (out_rrrid_o),
      .out_rbusy_o (out_rbusy_o),
      .out_wrrid_o (out_wrrid_o),
      .out_tier_o  (out_tier_o),
      .out_warid_o (out_warid_o),
      .c_retire_i  (c_retire_i),
      .c_warid_i   (c_warid_i),
      .c_wrrid_i   (c_wrrid_i),
      .c_flush_i   (c_flush_i),
      .empty_o     (empty_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // rarid packing: {l1p1, l1p0, l0p1, l0p0}; warid packing: {l1, l0}
   task automatic drive(input logic v, input logic [1:0] m, input logic [19:0] ra,
                        input logic [9:0] wa);
      in_valid_i = v;
      in_mask_i  = m;
      in_rarid_i = ra;
      in_warid_i = wa;
   endtask

   task automatic commit(input logic [1:0] ret, input logic [9:0] wa, input logic [11:0] wr);
      c_retire_i = ret;
      c_warid_i  = wa;
      c_wrrid_i  = wr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst         = 1'b1;
      out_ready_i = 1'b1;
      c_flush_i   = 1'b0;
      drive(1'b0, 2'b00, 20'd0, 10'd0);
      commit(2'b00, 10'd0, 12'd0);
      tick();
      tick();
      chk("rst_in_ready", in_ready_o, 1);
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_empty", empty_o, 1);
      chk("rst_wrrid", out_wrrid_o, 0);
      chk("rst_rbusy", out_rbusy_o, 0);
      chk("rst_mask", out_mask_o, 0);
      rst = 1'b0;

      // Lane0 writes 3, lane1 writes 5 and reads 3 (bypass from lane0).
      drive(1'b1, 2'b11, {5'd0, 5'd3, 5'd0, 5'd0}, {5'd5, 5'd3});
      tick();
      chk("b1_valid", out_valid_o, 1);
      chk("b1_wrrid", out_wrrid_o, {6'd1, 6'd0});
      chk("b1_rbusy", out_rbusy_o, 4'b0100);
      chk("b1_rrrid", out_rrrid_o, 24'd0);
      chk("b1_tier", out_tier_o, 2'b00);
      chk("b1_warid", out_warid_o, {5'd5, 5'd3});
      chk("b1_empty", empty_o, 0);

      // Both lanes write arch 7: lane1 (id 3) must win.
      drive(1'b1, 2'b11, 20'd0, {5'd7, 5'd7});
      tick();
      chk("b2_wrrid", out_wrrid_o, {6'd3, 6'd2});
      drive(1'b1, 2'b01, {5'd0, 5'd0, 5'd0, 5'd7}, 10'd0);
      tick();
      chk("b3_rbusy", out_rbusy_o, 4'b0001);
      chk("b3_rrrid", out_rrrid_o, 24'd3);
      chk("b3_wrrid", out_wrrid_o, 12'd4);

      // Commit id 0 (arch 3) while reading arch 3: forwarded as ready.
      chk("retire_legal_a", empty_o, 0);
      drive(1'b1, 2'b01, {5'd0, 5'd0, 5'd0, 5'd3}, 10'd0);
      commit(2'b01, {5'd0, 5'd3}, 12'd0);
      tick();
      commit(2'b00, 10'd0, 12'd0);
      chk("fwd_rbusy", out_rbusy_o, 4'b0000);
      chk("fwd_wrrid", out_wrrid_o, 12'd5);
      tick();
      chk("clr_rbusy", out_rbusy_o, 4'b0000);
      chk("clr_wrrid", out_wrrid_o, 12'd6);

      // Commit id 1 (arch 5) while a new bundle renames arch 5: the rename wins.
      drive(1'b1, 2'b01, 20'd0, {5'd0, 5'd5});
      commit(2'b01, {5'd0, 5'd5}, 12'd1);
      tick();
      commit(2'b00, 10'd0, 12'd0);
      chk("ovr_wrrid", out_wrrid_o, 12'd7);
      drive(1'b1, 2'b01, {5'd0, 5'd0, 5'd0, 5'd5}, 10'd0);
      tick();
      chk("ovr_rbusy", out_rbusy_o, 4'b0001);
      chk("ovr_rrrid", out_rrrid_o, 24'd7);

      // Commit id 2 for arch 7: map holds id 3, so arch 7 stays busy.
      drive(1'b0, 2'b00, 20'd0, 10'd0);
      commit(2'b01, {5'd0, 5'd7}, 12'd2);
      tick();
      commit(2'b00, 10'd0, 12'd0);
      drive(1'b1, 2'b01, {5'd0, 5'd0, 5'd0, 5'd7}, 10'd0);
      tick();
      chk("nomatch_rbusy", out_rbusy_o, 4'b0001);
      chk("nomatch_rrrid", out_rrrid_o, 24'd3);
      chk("nomatch_wrrid", out_wrrid_o, 12'd9);

      // Backpressure: output held for 3 cycles, second bundle parked in the skid.
      drive(1'b0, 2'b00, 20'd0, 10'd0);
      tick();
      chk("drain_valid", out_valid_o, 0);
      out_ready_i = 1'b0;
      drive(1'b1, 2'b01, 20'd0, {5'd0, 5'd9});
      tick();
      chk("stA_valid", out_valid_o, 1);
      chk("stA_wrrid", out_wrrid_o, 12'd10);
      drive(1'b1, 2'b01, 20'd0, {5'd0, 5'd10});
      tick();
      chk("st1_ready", in_ready_o, 0);
      chk("st1_wrrid", out_wrrid_o, 12'd10);
      drive(1'b0, 2'b00, 20'd0, 10'd0);
      tick();
      chk("st2_wrrid", out_wrrid_o, 12'd10);
      chk("st2_valid", out_valid_o, 1);
      tick();
      chk("st3_warid", out_warid_o, {5'd0, 5'd9});
      out_ready_i = 1'b1;
      tick();
      chk("stB_wrrid", out_wrrid_o, 12'd11);
      chk("stB_warid", out_warid_o, {5'd0, 5'd10});
      chk("stB_ready", in_ready_o, 1);
      tick();
      chk("stB_drain", out_valid_o, 0);

      // Flush with both skid and output occupied.
      out_ready_i = 1'b0;
      drive(1'b1, 2'b01, 20'd0, {5'd0, 5'd4});
      tick();
      drive(1'b1, 2'b01, 20'd0, {5'd0, 5'd6});
      tick();
      chk("fl_pre_ready", in_ready_o, 0);
      drive(1'b0, 2'b00, 20'd0, 10'd0);
      c_flush_i = 1'b1;
      tick();
      c_flush_i = 1'b0;
      out_ready_i = 1'b1;
      chk("fl_valid", out_valid_o, 0);
      chk("fl_empty", empty_o, 1);
      chk("fl_ready", in_ready_o, 1);
      drive(1'b1, 2'b11, {5'd9, 5'd7, 5'd5, 5'd3}, 10'd0);
      tick();
      chk("fl_rbusy", out_rbusy_o, 4'b0000);
      chk("fl_wrrid", out_wrrid_o, {6'd1, 6'd0});

      // Fill to 63 occupied (tail 2 -> 63).
      drive(1'b1, 2'b11, 20'd0, 10'd0);
      repeat (30) tick();
      drive(1'b1, 2'b01, 20'd0, 10'd0);
      tick();
      chk("fill_last", out_wrrid_o, 12'd62);
      drive(1'b1, 2'b11, 20'd0, 10'd0);
      tick();
      chk("full_ready", in_ready_o, 0);
      chk("full_nofire", out_valid_o, 0);
      drive(1'b0, 2'b00, 20'd0, 10'd0);
      tick();
      chk("full_hold", out_valid_o, 0);
      chk("retire_legal_b", empty_o, 0);
      commit(2'b01, 10'd0, 12'd0);
      tick();
      commit(2'b00, 10'd0, 12'd0);
      chk("ret_nofire", out_valid_o, 0);
      tick();
      chk("wrap_valid", out_valid_o, 1);
      chk("wrap_wrrid", out_wrrid_o, {6'd0, 6'd63});
      chk("wrap_tier", out_tier_o, 2'b10);
      chk("wrap_ready", in_ready_o, 1);

      // Completely full: only an empty mask may fire.
      drive(1'b1, 2'b00, 20'd0, 10'd0);
      tick();
      chk("z_valid", out_valid_o, 1);
      chk("z_mask", out_mask_o, 2'b00);
      chk("z_empty", empty_o, 0);
      drive(1'b1, 2'b01, 20'd0, 10'd0);
      tick();
      chk("blk_valid", out_valid_o, 0);
      chk("blk_ready", in_ready_o, 0);

      drive(1'b0, 2'b00, 20'd0, 10'd0);
      c_flush_i = 1'b1;
      tick();
      c_flush_i = 1'b0;
      chk("end_empty", empty_o, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
